// File: rtl/imm_extend_pipe_pkg.sv
// imm_extend_pipe_pkg: immediate format codes and shared constants for the decode-stage immediate unit.
package imm_pkg;
   localparam int INSTR_W = 32;
   localparam int XLEN32 = 32;
   localparam int XLEN64 = 64;
   typedef enum logic [2:0] {
      IMM_I   = 3'd0,
      IMM_U   = 3'd1,
      IMM_S   = 3'd2,
      IMM_B   = 3'd3,
      IMM_J   = 3'd4,
      IMM_Z   = 3'd5,
      IMM_SH  = 3'd6,
      IMM_ILL = 3'd7
   } imm_src_e;
   function automatic logic xlen_ok(int w);
      return w == XLEN32 || w == XLEN64;
   endfunction
endpackage

// File: rtl/imm_extend_pipe_if.sv
// imm_extend_pipe_if: valid/ready request and response bundle of the immediate unit.
interface imm_extend_pipe_if #(parameter int DATA_WIDTH = 32);
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [31:0]           instr_i;
   logic [DATA_WIDTH-1:0] pc_i;
   logic [2:0]            ImmSrc;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] Imm_o;
   logic [DATA_WIDTH-1:0] target_o;
   logic                  illegal_o;
   modport master (
      output flush, in_valid, instr_i, pc_i, ImmSrc, out_ready,
      input  in_ready, out_valid, Imm_o, target_o, illegal_o
   );
   modport slave (
      input  flush, in_valid, instr_i, pc_i, ImmSrc, out_ready,
      output in_ready, out_valid, Imm_o, target_o, illegal_o
   );
endinterface

// File: rtl/imm_extend_pipe_decode.sv
// imm_decode: combinational RISC-V immediate extraction and extension to DATA_WIDTH.
module imm_decode
   import imm_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [31:0]           instr,
   input  imm_src_e              src,
   output logic [DATA_WIDTH-1:0] imm,
   output logic                  illegal
);
   logic [31:0] raw;
   logic        unused_opcode;
   assign unused_opcode = ^instr[6:0];
   // Every format is first built as a 32-bit sign-correct value; zero-extended formats keep bit 31 clear.
   always_comb begin
      raw = '0;
      illegal = 1'b0;
      case (src)
         IMM_I:   raw = {{20{instr[31]}}, instr[31:20]};
         IMM_U:   raw = {instr[31:12], 12'b0};
         IMM_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         IMM_Z:   raw = {27'b0, instr[19:15]};
         IMM_SH:  raw = DATA_WIDTH == XLEN64 ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
         default: illegal = 1'b1;
      endcase
      imm = DATA_WIDTH'($signed(raw));
   end
endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: immediate generator and pc+imm adder behind a two-entry valid/ready skid buffer.
module imm_extend_pipe
   import imm_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input logic               clk,
   input logic               rst_n,
   imm_extend_pipe_if.slave  bus
);
   typedef struct packed {
      logic [DATA_WIDTH-1:0] imm;
      logic [DATA_WIDTH-1:0] target;
      logic                  illegal;
   } payload_t;
   if (!xlen_ok(DATA_WIDTH)) begin : g_bad_width
      $error("imm_extend_pipe: DATA_WIDTH must be 32 or 64");
   end
   payload_t              m_q, s_q, new_p;
   logic                  m_valid, s_valid, accept, m_free, illegal;
   logic [DATA_WIDTH-1:0] imm;
   imm_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
      .instr   (bus.instr_i),
      .src     (imm_src_e'(bus.ImmSrc)),
      .imm     (imm),
      .illegal (illegal)
   );
   always_comb begin
      new_p.imm = imm;
      new_p.target = bus.pc_i + imm;
      new_p.illegal = illegal;
   end
   // in_ready deliberately ignores out_ready so no combinational path crosses the buffer.
   assign bus.in_ready  = !s_valid && !bus.flush;
   assign accept        = bus.in_valid && bus.in_ready;
   assign m_free        = !m_valid || bus.out_ready;
   assign bus.out_valid = m_valid;
   assign bus.Imm_o     = m_q.imm;
   assign bus.target_o  = m_q.target;
   assign bus.illegal_o = m_q.illegal;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
         m_q <= '0;
         s_q <= '0;
      end else if (bus.flush) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
      end else if (m_free) begin
         m_valid <= s_valid || accept;
         s_valid <= 1'b0;
         if (s_valid) m_q <= s_q;
         else if (accept) m_q <= new_p;
      end else if (accept) begin
         s_valid <= 1'b1;
         s_q <= new_p;
      end
   end
endmodule
